add_result_acc: RTL and testbench

Downstream consumer of the 3-bit ripple adder stage. It takes each adder result (3-bit `sum` plus the final carry) through a valid/ready handshake and accumulates `BLOCK_LEN` results into a wider register. It then presents the block total with an overflow flag through an output handshake. It is the result/readout stage between the adder and board-level display logic.

---
 rtl/add_result_acc.sv | 137 +++++++++++++
 tb/tb_add_result_acc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/add_result_acc.sv
// add_result_acc
//   Result/readout stage behind the 3-bit ripple adder. It accepts adder results
//   through a valid/ready handshake and sums BLOCK_LEN of them into an ACC_W-bit
//   accumulator. It then presents the block total and a sticky overflow flag
//   through an output valid/ready handshake.
//
//   Optional feature macro: ACC_RESULT_SAT_EN
//     defined   : each add saturates to 2^ACC_W-1 on carry-out
//     undefined : each add wraps modulo 2^ACC_W
//   The overflow flag behaves the same in both builds.
//
// Parameters
//   ACC_W     : accumulator / result width (>= 4)
//   BLOCK_LEN : adder results per block (>= 1)
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset
//   in_valid  in   1      adder result presented
//   in_ready  out  1      block accepts a result this cycle
//   in_sum    in   3      adder sum[2:0]
//   in_cout   in   3      adder carry chain; only bit 2 is used
//   out_valid out  1      block total available
//   out_ready in   1      downstream accepts the total
//   out_acc   out  ACC_W  block total
//   out_ovf   out  1      overflow occurred during the block
module add_result_acc #(
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sum,
  input  logic [2:0]       in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Returns {carry, result}. The carry bit always reports the true carry-out,
  // so the sticky flag is updated the same way whether or not we saturate.
  function automatic logic [ACC_W:0] add_val(input logic [ACC_W-1:0] a,
                                             input logic [3:0]       v);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-3){1'b0}}, v};
`ifdef ACC_RESULT_SAT_EN
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
`endif
    return s;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_ovf_q, out_ovf_d;

  logic [3:0]       operand;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             unused_cout;

  // Lower carry-chain bits are not part of the operand.
  assign unused_cout = ^in_cout[1:0];

  assign operand = {in_cout[2], in_sum};
  assign sum_ext = add_val(acc_q, operand);

  // Handshake outputs come from the state register only.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            // Final beat: publish the total and start the next block clean.
            out_acc_d = sum_ext[ACC_W-1:0];
            out_ovf_d = ovf_q | sum_ext[ACC_W];
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ST_HOLD;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | sum_ext[ACC_W];
          end
        end
      end
      default: begin
        // HOLD: inputs are not consumed; the total stays put after release.
        if (out_ready) state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_acc_q <= out_acc_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_acc = out_acc_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_add_result_acc.sv
module tb_add_result_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT A: ACC_W=8, BLOCK_LEN=4
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [2:0] a_in_sum, a_in_cout;
  logic [7:0] a_out_acc;

  // DUT B: ACC_W=4, BLOCK_LEN=2
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [2:0] b_in_sum, b_in_cout;
  logic [3:0] b_out_acc;

  add_result_acc #(.ACC_W(8), .BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sum(a_in_sum), .in_cout(a_in_cout),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_ovf(a_out_ovf)
  );

  add_result_acc #(.ACC_W(4), .BLOCK_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sum(b_in_sum), .in_cout(b_in_cout),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf)
  );

  int checks   = 0;
  int failures = 0;

`ifdef ACC_RESULT_SAT_EN
  localparam logic [31:0] OVF_EXP_ACC = 32'd15;
`else
  localparam logic [31:0] OVF_EXP_ACC = 32'd14;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive value v (0..15) onto DUT A; noise goes into the ignored cout bits.
  task automatic drive_a(input logic vld, input logic [3:0] v, input logic [1:0] noise);
    a_in_valid = vld;
    a_in_sum   = v[2:0];
    a_in_cout  = {v[3], noise};
  endtask

  task automatic drive_b(input logic vld, input logic [3:0] v);
    b_in_valid = vld;
    b_in_sum   = v[2:0];
    b_in_cout  = {v[3], 2'b00};
  endtask

  initial begin
    rst_n = 1'b0;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    drive_a(1'b0, 4'd0, 2'b00);
    drive_b(1'b0, 4'd0);

    // Reset
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_acc",   a_out_acc,   0);
    check("rst_out_ovf",   a_out_ovf,   0);
    check("rst_b_in_ready", b_in_ready, 1);

    // Full block of 15s
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'd15, 2'b11);
      step();
      if (i < 3) check("full_no_early_valid", a_out_valid, 0);
    end
    drive_a(1'b0, 4'd0, 2'b00);
    check("full_out_valid", a_out_valid, 1);
    check("full_in_ready",  a_in_ready,  0);
    check("full_out_acc",   a_out_acc,   60);
    check("full_out_ovf",   a_out_ovf,   0);
    step();
    check("full_valid_drop", a_out_valid, 0);
    check("full_in_ready_back", a_in_ready, 1);
    check("full_acc_kept", a_out_acc, 60);

    // Backpressure: block 1,2,3,4 with out_ready low
    a_out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      drive_a(1'b1, 4'(v), 2'b00);
      step();
    end
    check("bp_out_valid", a_out_valid, 1);
    check("bp_out_acc",   a_out_acc,   10);
    drive_a(1'b1, 4'd7, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_ready", a_in_ready,  0);
      check("bp_hold_acc",   a_out_acc,   10);
    end
    a_out_ready = 1'b1;
    drive_a(1'b0, 4'd0, 2'b00);
    step();
    check("bp_release_ready", a_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'd1, 2'b00);
      step();
    end
    drive_a(1'b0, 4'd0, 2'b00);
    check("bp_next_valid", a_out_valid, 1);
    check("bp_next_acc",   a_out_acc,   4);
    step();

    // Mid-block reset
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b1, 4'd5, 2'b00);
      step();
    end
    drive_a(1'b0, 4'd0, 2'b00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_acc_cleared", a_out_acc, 0);
    check("mrst_in_ready", a_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'd1, 2'b00);
      step();
      if (i < 3) check("mrst_no_early_valid", a_out_valid, 0);
    end
    drive_a(1'b0, 4'd0, 2'b00);
    check("mrst_out_valid", a_out_valid, 1);
    check("mrst_out_acc",   a_out_acc,   4);
    step();

    // Gapped input: 3, idle, idle, 6, idle, 0, 9; garbage on idle and cout[1:0]
    drive_a(1'b1, 4'd3, 2'b11);  step(); check("gap_v0", a_out_valid, 0);
    drive_a(1'b0, 4'd15, 2'b10); step(); check("gap_v1", a_out_valid, 0);
    drive_a(1'b0, 4'd12, 2'b01); step(); check("gap_v2", a_out_valid, 0);
    drive_a(1'b1, 4'd6, 2'b01);  step(); check("gap_v3", a_out_valid, 0);
    drive_a(1'b0, 4'd15, 2'b11); step(); check("gap_v4", a_out_valid, 0);
    drive_a(1'b1, 4'd0, 2'b11);  step(); check("gap_v5", a_out_valid, 0);
    drive_a(1'b1, 4'd9, 2'b10);  step();
    drive_a(1'b0, 4'd0, 2'b00);
    check("gap_out_valid", a_out_valid, 1);
    check("gap_out_acc",   a_out_acc,   18);
    check("gap_out_ovf",   a_out_ovf,   0);
    step();
    check("gap_single_valid", a_out_valid, 0);

    // Overflow on DUT B (ACC_W=4, BLOCK_LEN=2)
    b_out_ready = 1'b1;
    drive_b(1'b1, 4'd15); step();
    check("ovf_no_early_valid", b_out_valid, 0);
    drive_b(1'b1, 4'd15); step();
    drive_b(1'b0, 4'd0);
    check("ovf_out_valid", b_out_valid, 1);
    check("ovf_out_acc",   b_out_acc,   OVF_EXP_ACC);
    check("ovf_out_ovf",   b_out_ovf,   1);
    step();
    check("ovf_ready_back", b_in_ready, 1);
    drive_b(1'b1, 4'd1); step();
    drive_b(1'b1, 4'd2); step();
    drive_b(1'b0, 4'd0);
    check("ovf_next_valid", b_out_valid, 1);
    check("ovf_next_acc",   b_out_acc,   3);
    check("ovf_next_ovf",   b_out_ovf,   0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
